// File: rtl/contador_pkg.sv
// contador_pkg: shared types and helpers for the arbitrary-sequence counter.
package contador_pkg;
    typedef enum logic {SYNC, UNSYNC} state_t;
    function automatic int iw(input int depth);
        return $clog2(depth);
    endfunction
    // Reset table holds the natural count 0,1,2,... truncated to the output width.
    function automatic logic [31:0] reset_entry(input int i, input int width);
        return 32'(i) & ((32'd1 << width) - 32'd1);
    endfunction
endpackage

// File: rtl/contador_secuencia_param_if.sv
// contador_secuencia_param_if: control/status bundle; dir exists only with CONTADOR_DOWN_EN.
interface contador_secuencia_param_if #(parameter int WIDTH = 4, parameter int DEPTH = 8);
    import contador_pkg::*;
    localparam int IW = iw(DEPTH);
    logic en;
    logic pre_en;
    logic [WIDTH-1:0] pre_val;
    logic wr_en;
    logic [IW-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic len_we;
    logic [IW:0] len_val;
`ifdef CONTADOR_DOWN_EN
    logic dir;
`endif
    logic [WIDTH-1:0] Q;
    logic [IW-1:0] idx;
    logic wrap;
    logic oos;
    modport master (
        output en, pre_en, pre_val, wr_en, wr_addr, wr_data, len_we, len_val,
`ifdef CONTADOR_DOWN_EN
        output dir,
`endif
        input Q, idx, wrap, oos
    );
    modport slave (
        input en, pre_en, pre_val, wr_en, wr_addr, wr_data, len_we, len_val,
`ifdef CONTADOR_DOWN_EN
        input dir,
`endif
        output Q, idx, wrap, oos
    );
endinterface

// File: rtl/contador_seq_match.sv
// contador_seq_match: lowest active table index whose entry equals val.
module contador_seq_match
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int IW = iw(DEPTH)
) (
    input  logic [WIDTH-1:0] val,
    input  logic [WIDTH-1:0] seq [DEPTH],
    input  logic [IW:0]      len,
    output logic             hit,
    output logic [IW-1:0]    k
);
    // Scan from the top so the lowest matching index is the one that survives.
    always_comb begin
        hit = 1'b0;
        k = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if ((IW+1)'(i) < len && seq[i] == val) begin
                hit = 1'b1;
                k = IW'(i);
            end
    end
endmodule

// File: rtl/contador_secuencia_param.sv
// contador_secuencia_param: programmable-table sequence counter with preset and resync.
// Backward stepping and the dir port are built only when CONTADOR_DOWN_EN is defined.
module contador_secuencia_param
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input logic C,
    input logic R,
    contador_secuencia_param_if.slave bus
);
    localparam int IW = iw(DEPTH);
    localparam logic [IW:0] LEN_MAX = (IW+1)'(DEPTH);
    logic [WIDTH-1:0] seq [DEPTH];
    logic [IW:0] len;
    logic [WIDTH-1:0] q;
    logic [IW-1:0] idx;
    logic wrap;
    state_t state;
    logic hit;
    logic [IW-1:0] hit_idx;
    logic [IW:0] idx_x;
    logic shrink;
    logic last;
    logic [IW-1:0] step_idx;
    logic step_wrap;
    logic [IW:0] len_clamp;
    logic wr_ok;

    contador_seq_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match (
        .val(bus.pre_val),
        .seq(seq),
        .len(len),
        .hit(hit),
        .k(hit_idx)
    );

    // An index left beyond a shrunken length counts as past the end and wraps to 0.
    assign idx_x = {1'b0, idx};
    assign shrink = idx_x >= len;
    assign last = idx_x + 1'b1 >= len;
`ifdef CONTADOR_DOWN_EN
    assign step_wrap = bus.dir ? (shrink || idx == '0) : last;
    assign step_idx = bus.dir ? (shrink ? '0 : idx == '0 ? IW'(len - 1'b1) : idx - 1'b1)
                              : (last ? '0 : idx + 1'b1);
`else
    assign step_wrap = last;
    assign step_idx = last ? '0 : idx + 1'b1;
`endif
    assign len_clamp = bus.len_val == '0 ? (IW+1)'(1) : bus.len_val > LEN_MAX ? LEN_MAX : bus.len_val;
    assign wr_ok = {1'b0, bus.wr_addr} < LEN_MAX;

    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++)
                seq[i] <= WIDTH'(reset_entry(i, WIDTH));
            len <= LEN_MAX;
            q <= '0;
            idx <= '0;
            wrap <= 1'b0;
            state <= SYNC;
        end else begin
            wrap <= 1'b0;
            if (bus.pre_en) begin
                q <= bus.pre_val;
                idx <= hit ? hit_idx : '0;
                state <= hit ? SYNC : UNSYNC;
            end else if (bus.en) begin
                if (state == UNSYNC) begin
                    q <= seq[0];
                    idx <= '0;
                    state <= SYNC;
                end else begin
                    q <= seq[step_idx];
                    idx <= step_idx;
                    wrap <= step_wrap;
                end
            end
            if (bus.wr_en && wr_ok)
                seq[bus.wr_addr] <= bus.wr_data;
            if (bus.len_we)
                len <= len_clamp;
        end
    end

    assign bus.Q = q;
    assign bus.idx = idx;
    assign bus.wrap = wrap;
    assign bus.oos = state == UNSYNC;
endmodule

// File: tb/tb_contador_secuencia_param.sv
// tb_contador_secuencia_param: directed plan plus random traffic against a table-level model.
module tb_contador_secuencia_param;
    logic C = 1'b0;
    logic R;
    int compared = 0;
    int mismatched = 0;
    bit s_r, s_en, s_pre, s_we, s_lwe, s_dir;
    int s_pv, s_wa, s_wd, s_lv;
    int m_seq[8];
    int m_len, m_q, m_idx;
    bit m_oos, m_wrap;
    int prog[8] = '{2, 3, 4, 5, 6, 7, 10, 12};
    int oos_vals[6] = '{0, 1, 8, 9, 11, 13};
    int exp_prog[8] = '{3, 4, 5, 6, 7, 10, 12, 2};

    contador_secuencia_param_if #(.WIDTH(4), .DEPTH(8)) bus ();
    contador_secuencia_param #(.WIDTH(4), .DEPTH(8)) dut (.C(C), .R(R), .bus(bus));

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        {s_r, s_en, s_pre, s_we, s_lwe, s_dir} = '0;
        {s_pv, s_wa, s_wd, s_lv} = '0;
    endtask

    // Sequence position semantics: m_oos means Q is off the table; Q itself is kept separately.
    task automatic model_edge();
        int k;
        bit back;
        back = 1'b0;
`ifdef CONTADOR_DOWN_EN
        back = s_dir;
`endif
        if (s_r) begin
            foreach (m_seq[i]) m_seq[i] = i;
            m_len = 8; m_q = 0; m_idx = 0; m_oos = 0; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (s_pre) begin
            k = -1;
            for (int i = 0; i < m_len && k < 0; i++)
                if (m_seq[i] == s_pv) k = i;
            m_q = s_pv;
            m_oos = k < 0;
            m_idx = k < 0 ? 0 : k;
        end else if (s_en) begin
            if (m_oos) begin
                m_oos = 0;
                m_idx = 0;
            end else if (m_idx >= m_len) begin
                m_idx = 0; m_wrap = 1;
            end else if (back) begin
                m_wrap = m_idx == 0;
                m_idx = (m_idx + m_len - 1) % m_len;
            end else begin
                m_wrap = m_idx == m_len - 1;
                m_idx = (m_idx + 1) % m_len;
            end
            m_q = m_seq[m_idx];
        end
        if (s_we) m_seq[s_wa] = s_wd;
        if (s_lwe) m_len = s_lv < 1 ? 1 : s_lv > 8 ? 8 : s_lv;
    endtask

    task automatic step();
        R = s_r;
        bus.en = s_en; bus.pre_en = s_pre; bus.pre_val = 4'(s_pv);
        bus.wr_en = s_we; bus.wr_addr = 3'(s_wa); bus.wr_data = 4'(s_wd);
        bus.len_we = s_lwe; bus.len_val = 4'(s_lv);
`ifdef CONTADOR_DOWN_EN
        bus.dir = s_dir;
`endif
        @(posedge C);
        model_edge();
        #1;
        chk("model_q", bus.Q, m_q);
        chk("model_idx", bus.idx, m_idx);
        chk("model_wrap", bus.wrap, m_wrap);
        chk("model_oos", bus.oos, m_oos);
    endtask

    initial begin
        clear(); s_r = 1; step();
        chk("rst_q", bus.Q, 0); chk("rst_idx", bus.idx, 0);
        chk("rst_wrap", bus.wrap, 0); chk("rst_oos", bus.oos, 0);

        for (int i = 0; i < 10; i++) begin
            clear(); s_en = 1; step();
            chk("rst_seq_q", bus.Q, (i + 1) % 8);
            chk("rst_seq_wrap", bus.wrap, i == 7);
        end

        for (int i = 0; i < 8; i++) begin
            clear(); s_we = 1; s_wa = i; s_wd = prog[i]; s_lwe = i == 7; s_lv = 8; step();
        end
        clear(); s_pre = 1; s_pv = 2; step();
        chk("prog_pre_q", bus.Q, 2);
        for (int i = 0; i < 8; i++) begin
            clear(); s_en = 1; step();
            chk("prog_q", bus.Q, exp_prog[i]);
            chk("prog_wrap", bus.wrap, i == 7);
            chk("prog_oos", bus.oos, 0);
        end

        foreach (oos_vals[j]) begin
            clear(); s_pre = 1; s_pv = oos_vals[j]; step();
            chk("oos_q", bus.Q, oos_vals[j]); chk("oos_flag", bus.oos, 1);
            clear(); s_en = 1; step();
            chk("resync_q", bus.Q, 2); chk("resync_idx", bus.idx, 0);
            chk("resync_oos", bus.oos, 0); chk("resync_wrap", bus.wrap, 0);
        end

        clear(); s_pre = 1; s_pv = 10; step();
        chk("pre10_idx", bus.idx, 6);
        clear(); s_lwe = 1; s_lv = 4; step();
        chk("shrink_hold_q", bus.Q, 10);
        clear(); s_en = 1; step();
        chk("shrink_q", bus.Q, 2); chk("shrink_wrap", bus.wrap, 1);
        clear(); s_lwe = 1; s_lv = 8; step();

        clear(); s_pre = 1; s_pv = 5; s_en = 1; step();
        chk("pre_wins_q", bus.Q, 5); chk("pre_wins_idx", bus.idx, 3);
        for (int i = 0; i < 5; i++) begin
            clear(); step();
            chk("hold_q", bus.Q, 5);
        end

`ifdef CONTADOR_DOWN_EN
        clear(); s_pre = 1; s_pv = 2; s_dir = 1; step();
        clear(); s_en = 1; s_dir = 1; step();
        chk("back_q1", bus.Q, 12); chk("back_wrap1", bus.wrap, 1);
        clear(); s_en = 1; s_dir = 1; step();
        chk("back_q2", bus.Q, 10); chk("back_wrap2", bus.wrap, 0);
`endif

        clear(); s_r = 1; s_we = 1; s_wa = 3; s_wd = 15; step();
        chk("rst_wr_q", bus.Q, 0);
        for (int i = 0; i < 3; i++) begin
            clear(); s_en = 1; step();
        end
        chk("rst_wr_entry3", bus.Q, 3);

        for (int i = 0; i < 400; i++) begin
            clear();
            s_r = $urandom_range(63) == 0;
            s_en = $urandom_range(1);
            s_pre = $urandom_range(7) == 0;
            s_pv = $urandom_range(15);
            s_we = $urandom_range(3) == 0;
            s_wa = $urandom_range(7);
            s_wd = $urandom_range(15);
            s_lwe = $urandom_range(15) == 0;
            s_lv = $urandom_range(15);
            s_dir = $urandom_range(1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
